bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_pkg.sv | 35 +++
 rtl/bus_rr_pick.sv | 32 +++
 rtl/bus_arbiter.sv | 115 +++++++++++
 tb/tb_bus_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions: master count, one-hot grant constants, arbiter
// state encoding and the round-robin pick result record.
package bus_pkg;

  localparam int NUM_MASTERS = 4;
  localparam int IDX_W       = 2;

  localparam logic [NUM_MASTERS-1:0] GRANT_M0 = 4'b0001;
  localparam logic [NUM_MASTERS-1:0] GRANT_M1 = 4'b0010;
  localparam logic [NUM_MASTERS-1:0] GRANT_M2 = 4'b0100;
  localparam logic [NUM_MASTERS-1:0] GRANT_M3 = 4'b1000;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] winner;
  } pick_t;

  // Master index to its one-hot grant pattern.
  function automatic logic [NUM_MASTERS-1:0] idx_to_grant(input logic [IDX_W-1:0] idx);
    logic [NUM_MASTERS-1:0] g;
    case (idx)
      2'd0:    g = GRANT_M0;
      2'd1:    g = GRANT_M1;
      2'd2:    g = GRANT_M2;
      default: g = GRANT_M3;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational round-robin picker: scans masters upward from the one after
// last_owner, wrapping, and returns the first requester not masked by excl.
module bus_rr_pick
  import bus_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last_owner,
  input  logic [NUM_MASTERS-1:0] excl,
  output logic                   valid,
  output logic [IDX_W-1:0]       winner
);

  logic [NUM_MASTERS-1:0] cand;
  logic [IDX_W-1:0]       idx;

  assign cand = req & ~excl;

  // First eligible candidate in rotated order; offset NUM_MASTERS lands back on last_owner.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = last_owner + IDX_W'(i);
      if (!valid && cand[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with registered one-hot grants and
// hold-limit preemption of an owner that keeps the bus while others wait.
module bus_arbiter #(
  parameter int HOLD_LIMIT  = 16,
  parameter int NUM_MASTERS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m0_req_i,
  input  logic       m1_req_i,
  input  logic       m2_req_i,
  input  logic       m3_req_i,
  output logic       m0_grnt_o,
  output logic       m1_grnt_o,
  output logic       m2_grnt_o,
  output logic       m3_grnt_o,
  output logic [1:0] owner_o,
  output logic       bus_busy_o
);

  import bus_pkg::*;

  // The grant ports are fixed at four masters; any other count is a build error.
  if (NUM_MASTERS != bus_pkg::NUM_MASTERS) begin : g_bad_num_masters
    $error("bus_arbiter: NUM_MASTERS must be 4");
  end
  if (HOLD_LIMIT < 0) begin : g_bad_hold_limit
    $error("bus_arbiter: HOLD_LIMIT must be >= 0");
  end

  localparam int CNT_W = (HOLD_LIMIT < 1) ? 1 : $clog2(HOLD_LIMIT + 1);
  localparam logic [CNT_W-1:0] HOLD_SAT = CNT_W'(HOLD_LIMIT);
  localparam logic [CNT_W-1:0] PRE_AT   = (HOLD_LIMIT > 0) ? CNT_W'(HOLD_LIMIT - 1) : '0;
  localparam logic             PRE_EN   = (HOLD_LIMIT > 0);

  logic [3:0]       req;
  arb_state_e       state;
  logic [3:0]       grant;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] last_owner;
  logic [CNT_W-1:0] hold_cnt;

  logic             owner_req;
  logic             others_req;
  logic             preempt;
  pick_t            pick;

  assign req = {m3_req_i, m2_req_i, m1_req_i, m0_req_i};

  // grant is zero in IDLE, so these reduce to "any request" / "no owner" there.
  assign owner_req  = |(req & grant);
  assign others_req = |(req & ~grant);

  // Once the count has reached the limit point (or saturated past it while the
  // owner was alone), the first competing request takes the bus at the next edge.
  assign preempt = PRE_EN && owner_req && others_req && (hold_cnt >= PRE_AT);

  // The current owner is masked out so a preemption always hands the bus on.
  bus_rr_pick u_pick (
    .req        (req),
    .last_owner (last_owner),
    .excl       (grant),
    .valid      (pick.valid),
    .winner     (pick.winner)
  );

  // Arbiter FSM; grant, owner and hold count are all registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      owner      <= '0;
      last_owner <= 2'd3;
      hold_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick.valid) begin
            state      <= OWNED;
            grant      <= idx_to_grant(pick.winner);
            owner      <= pick.winner;
            last_owner <= pick.winner;
            hold_cnt   <= '0;
          end
        end
        OWNED: begin
          if (owner_req && !preempt) begin
            if (hold_cnt != HOLD_SAT) hold_cnt <= hold_cnt + 1'b1;
          end else if (pick.valid) begin
            grant      <= idx_to_grant(pick.winner);
            owner      <= pick.winner;
            last_owner <= pick.winner;
            hold_cnt   <= '0;
          end else begin
            state    <= IDLE;
            grant    <= '0;
            hold_cnt <= '0;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  assign m0_grnt_o  = grant[0];
  assign m1_grnt_o  = grant[1];
  assign m2_grnt_o  = grant[2];
  assign m3_grnt_o  = grant[3];
  assign owner_o    = owner;
  assign bus_busy_o = (state == OWNED);

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: three instances (hold limits 16, 1, 0) share one
// request stream and are tracked by an abstract per-instance model.
module tb_bus_arbiter;

  localparam int NI = 3;
  localparam int LIMS [NI] = '{16, 1, 0};

  logic       clk;
  logic       rst;
  logic [3:0] req;

  logic [3:0] gnt_a  [NI];
  logic [1:0] own_a  [NI];
  logic       busy_a [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [3:0] gv;
    bus_arbiter #(.HOLD_LIMIT(LIMS[g]), .NUM_MASTERS(4)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .m0_req_i   (req[0]),
      .m1_req_i   (req[1]),
      .m2_req_i   (req[2]),
      .m3_req_i   (req[3]),
      .m0_grnt_o  (gv[0]),
      .m1_grnt_o  (gv[1]),
      .m2_grnt_o  (gv[2]),
      .m3_grnt_o  (gv[3]),
      .owner_o    (own_a[g]),
      .bus_busy_o (busy_a[g])
    );
    assign gnt_a[g] = gv;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model: owner index (-1 = nobody), last winner, cycles owned so far.
  int mo [NI];
  int ml [NI];
  int mh [NI];

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] owner;
  } vec_t;

  vec_t tab [12];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d, want %0d", nm, cyc, act, exp);
    end
  endtask

  // First requester after 'last' in circular order, skipping 'excl'.
  function automatic int rr_pick(input logic [3:0] r, input int last, input int excl);
    for (int i = 1; i <= 4; i++) begin
      int c;
      c = (last + i) % 4;
      if (r[c] && c != excl) return c;
    end
    return -1;
  endfunction

  task automatic model_step(input int k, input logic [3:0] r, input logic rs);
    int w;
    logic others;
    if (rs) begin
      mo[k] = -1; ml[k] = 3; mh[k] = 0;
    end else if (mo[k] < 0) begin
      w = rr_pick(r, ml[k], -1);
      if (w >= 0) begin mo[k] = w; ml[k] = w; mh[k] = 1; end
    end else begin
      others = (r & ~(4'b0001 << mo[k])) != 4'b0000;
      if (r[mo[k]] && !(LIMS[k] > 0 && mh[k] >= LIMS[k] && others)) begin
        mh[k]++;
      end else begin
        w = rr_pick(r, ml[k], mo[k]);
        if (w >= 0) begin mo[k] = w; ml[k] = w; mh[k] = 1; end
        else begin mo[k] = -1; mh[k] = 0; end
      end
    end
  endtask

  // One clock: drive, sample 1 time unit after the edge, check every instance.
  task automatic step(input logic [3:0] r, input logic rs);
    req = r;
    rst = rs;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < NI; k++) begin
      model_step(k, r, rs);
      chk($sformatf("grant[L=%0d]", LIMS[k]), int'(gnt_a[k]),
          (mo[k] >= 0) ? (1 << mo[k]) : 0);
      chk($sformatf("busy[L=%0d]", LIMS[k]), int'(busy_a[k]), int'(mo[k] >= 0));
      if (mo[k] >= 0) chk($sformatf("owner[L=%0d]", LIMS[k]), int'(own_a[k]), mo[k]);
      chk($sformatf("onehot0[L=%0d]", LIMS[k]), int'($onehot0(gnt_a[k])), 1);
      chk($sformatf("busy_vs_grant[L=%0d]", LIMS[k]), int'(busy_a[k]), int'(|gnt_a[k]));
      if (busy_a[k])
        chk($sformatf("owner_vs_grant[L=%0d]", LIMS[k]), int'(gnt_a[k][own_a[k]]), 1);
    end
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] e;

    tab[0]  = '{4'b1111, 4'b0001, 2'd0};
    tab[1]  = '{4'b1111, 4'b0001, 2'd0};
    tab[2]  = '{4'b1111, 4'b0001, 2'd0};
    tab[3]  = '{4'b1110, 4'b0010, 2'd1};
    tab[4]  = '{4'b1110, 4'b0010, 2'd1};
    tab[5]  = '{4'b1110, 4'b0010, 2'd1};
    tab[6]  = '{4'b1100, 4'b0100, 2'd2};
    tab[7]  = '{4'b1100, 4'b0100, 2'd2};
    tab[8]  = '{4'b1000, 4'b1000, 2'd3};
    tab[9]  = '{4'b0000, 4'b0000, 2'd0};
    tab[10] = '{4'b0010, 4'b0010, 2'd1};
    tab[11] = '{4'b0000, 4'b0000, 2'd0};

    req = 4'b1111;
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin mo[k] = -1; ml[k] = 3; mh[k] = 0; end

    // Reset with every master already requesting.
    step(4'b1111, 1'b1);
    step(4'b1111, 1'b1);
    chk("reset_grant", int'(gnt_a[0]), 0);
    chk("reset_busy", int'(busy_a[0]), 0);
    chk("reset_owner", int'(own_a[0]), 0);

    // m0 first after reset, handovers without bubbles, idle gap, re-grant.
    for (int i = 0; i < 12; i++) begin
      step(tab[i].req, 1'b0);
      chk($sformatf("vec%0d_grant", i), int'(gnt_a[0]), int'(tab[i].grant));
      chk($sformatf("vec%0d_busy", i), int'(busy_a[0]), int'(|tab[i].grant));
      if (|tab[i].grant) chk($sformatf("vec%0d_owner", i), int'(own_a[0]), int'(tab[i].owner));
    end

    // Lone requester keeps the bus well past the hold limit.
    for (int i = 0; i < 40; i++) begin
      step(4'b0100, 1'b0);
      chk("solo_m2_grant", int'(gnt_a[0]), 4);
    end
    step(4'b0000, 1'b0);
    chk("solo_release", int'(gnt_a[0]), 0);

    // m1 and m3 contend: 16-cycle turns m1 -> m3 -> m1.
    step(4'b0000, 1'b1);
    for (int c = 1; c <= 48; c++) begin
      step(4'b1010, 1'b0);
      e = (c <= 16 || c > 32) ? 4'b0010 : 4'b1000;
      chk($sformatf("alt_c%0d", c), int'(gnt_a[0]), int'(e));
    end

    // Reset mid-transfer drops the grant at that edge; m0 wins afterwards.
    step(4'b0000, 1'b0);
    step(4'b0100, 1'b0);
    chk("pre_rst_m2", int'(gnt_a[0]), 4);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b1);
    chk("rst_mid_grant", int'(gnt_a[0]), 0);
    chk("rst_mid_busy", int'(busy_a[0]), 0);
    chk("rst_mid_owner", int'(own_a[0]), 0);
    step(4'b1111, 1'b0);
    chk("post_rst_m0", int'(gnt_a[0]), 1);

    // Sticky random requests with rare resets, checked against the model.
    r = 4'b1111;
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(7) == 0) r[b] = ~r[b];
      step(r, $urandom_range(199) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
